output_deskew_buffer: RTL and testbench

//  Realigns the diagonally skewed result stream leaving the systolic array (column j

---
 rtl/output_deskew_buffer.sv | 128 ++++++++++++
 tb/tb_output_deskew_buffer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/output_deskew_buffer.sv
// Realigns the diagonally skewed systolic-array output into flat rows, queued in a
// small FWFT row FIFO. Define DESKEW_ALIGN_CHECK_EN to require all lane valids per row.
module output_deskew_buffer #(
  parameter int N      = 2,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             clear_in,
  input  logic signed [N-1:0][DATA_W-1:0]  skewed_data_in,
  input  logic        [N-1:0]              skewed_valid_in,
  output logic signed [N-1:0][DATA_W-1:0]  flat_data_out,
  output logic                             flat_valid_out,
  input  logic                             flat_ready_in,
  output logic        [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic                             overflow,
  output logic                             align_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [N-1:0][DATA_W-1:0] row_data;
  logic [N-1:0]             row_vld;
  logic                     row_v;

  // Deskew: lane j waits N-1-j cycles so every lane of a row lines up with lane N-1.
  for (genvar j = 0; j < N; j++) begin : g_lane
    localparam int D = N - 1 - j;
    if (D == 0) begin : g_pass
      assign row_data[j] = skewed_data_in[j];
      assign row_vld[j]  = skewed_valid_in[j];
    end else begin : g_dly
      logic [DATA_W-1:0] dat_q [D];
      logic [D-1:0]      vld_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int k = 0; k < D; k++) dat_q[k] <= '0;
          vld_q <= '0;
        end else if (clear_in) begin
          for (int k = 0; k < D; k++) dat_q[k] <= '0;
          vld_q <= '0;
        end else begin
          dat_q[0] <= skewed_data_in[j];
          vld_q[0] <= skewed_valid_in[j];
          for (int k = 1; k < D; k++) begin
            dat_q[k] <= dat_q[k-1];
            vld_q[k] <= vld_q[k-1];
          end
        end
      end

      assign row_data[j] = dat_q[D-1];
      assign row_vld[j]  = vld_q[D-1];
    end
  end

`ifdef DESKEW_ALIGN_CHECK_EN
  logic align_hit;
  logic align_err_q;

  // A partially valid row is a skew fault: flag it and drop the row.
  assign align_hit = (|row_vld) && !(&row_vld);
  assign row_v     = &row_vld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           align_err_q <= 1'b0;
    else if (clear_in) align_err_q <= 1'b0;
    else if (align_hit) align_err_q <= 1'b1;
  end

  assign align_err = align_err_q;
`else
  logic unused_lane_vld;

  assign row_v           = row_vld[0];
  assign unused_lane_vld = ^row_vld[N-1:1];
  assign align_err       = 1'b0;
`endif

  logic [N-1:0][DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]            count_q, count_d;
  logic                     overflow_q, overflow_d;
  logic                     full, pop, push;

  always_comb begin
    full       = (count_q == CW'(DEPTH));
    pop        = (count_q != '0) && flat_ready_in;
    push       = row_v && (!full || pop);
    wr_ptr_d   = wr_ptr_q + PW'(push);
    rd_ptr_d   = rd_ptr_q + PW'(pop);
    count_d    = count_q + CW'(push) - CW'(pop);
    overflow_d = overflow_q | (row_v && full && !pop);
  end

  // Row FIFO: the array cannot be stalled, so a row arriving at a full FIFO is lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else if (clear_in) begin
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) mem_q[wr_ptr_q] <= row_data;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign flat_data_out  = mem_q[rd_ptr_q];
  assign flat_valid_out = (count_q != '0);
  assign fifo_count     = count_q;
  assign overflow       = overflow_q;

endmodule

// File: tb/tb_output_deskew_buffer.sv
// Directed bench for output_deskew_buffer (N=4, DEPTH=4) with a queue-based row scoreboard.
module tb_output_deskew_buffer;
  localparam int N = 4;
  localparam int DW = 16;
  localparam int DEPTH = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   clear_in;
  logic [N-1:0][DW-1:0]   skewed_data_in;
  logic [N-1:0]           skewed_valid_in;
  logic [N-1:0][DW-1:0]   flat_data_out;
  logic                   flat_valid_out;
  logic                   flat_ready_in;
  logic [2:0]             fifo_count;
  logic                   overflow;
  logic                   align_err;

  output_deskew_buffer #(.N(N), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .clear_in(clear_in),
    .skewed_data_in(skewed_data_in), .skewed_valid_in(skewed_valid_in),
    .flat_data_out(flat_data_out), .flat_valid_out(flat_valid_out),
    .flat_ready_in(flat_ready_in), .fifo_count(fifo_count),
    .overflow(overflow), .align_err(align_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [63:0] sb[$];
  logic [N-1:0][DW-1:0] rows[$];
  logic [N-1:0][DW-1:0] exp_row;
  logic [N-1:0][DW-1:0] tmp_row;
  bit row_evt = 0;
  bit ae_evt = 0;
  logic exp_ovf = 1'b0;
  logic exp_ae = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: compare against the model, update the model, advance.
  task automatic tick();
    bit pop;
    chk("valid", 64'(flat_valid_out), 64'(sb.size() != 0));
    chk("count", 64'(fifo_count), 64'(sb.size()));
    chk("overflow", 64'(overflow), 64'(exp_ovf));
    chk("align_err", 64'(align_err), 64'(exp_ae));
    if (sb.size() != 0) chk("head_data", flat_data_out, sb[0]);
    pop = flat_ready_in && (sb.size() != 0);
    if (clear_in) begin
      sb.delete();
      exp_ovf = 1'b0;
      exp_ae = 1'b0;
    end else begin
      if (pop) void'(sb.pop_front());
      if (row_evt) begin
        if (sb.size() < DEPTH) sb.push_back(exp_row);
        else exp_ovf = 1'b1;
      end
      if (ae_evt) exp_ae = 1'b1;
    end
    row_evt = 0;
    ae_evt = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int ncyc, input logic rdy);
    skewed_valid_in = '0;
    skewed_data_in = '0;
    flat_ready_in = rdy;
    for (int i = 0; i < ncyc; i++) tick();
  endtask

  // Feed rows[0..nrows-1] diagonally; ready rises at cycle rdy_from.
  task automatic stream(input int nrows, input int rdy_from);
    int r;
    for (int c = 0; c < nrows + N - 1; c++) begin
      for (int j = 0; j < N; j++) begin
        r = c - j;
        skewed_valid_in[j] = (r >= 0 && r < nrows);
        skewed_data_in[j] = (r >= 0 && r < nrows) ? rows[r][j] : '0;
      end
      flat_ready_in = (c >= rdy_from);
      r = c - (N - 1);
      if (r >= 0 && r < nrows) begin
        row_evt = 1;
        exp_row = rows[r];
      end
      tick();
    end
    skewed_valid_in = '0;
    skewed_data_in = '0;
  endtask

  task automatic make_rows(input int nrows, input int base);
    rows.delete();
    for (int r = 0; r < nrows; r++) begin
      for (int j = 0; j < N; j++) tmp_row[j] = 16'(base + 16 * r + j + 1);
      rows.push_back(tmp_row);
    end
  endtask

  // Two queued rows plus lanes 0,1 of a third row still inside the delay lines.
  task automatic load_with_inflight();
    make_rows(2, 16'h100);
    stream(2, 100);
    skewed_valid_in = 4'b0001; skewed_data_in = '0; skewed_data_in[0] = 16'h0AA;
    flat_ready_in = 1'b0;
    tick();
    skewed_valid_in = 4'b0010; skewed_data_in = '0; skewed_data_in[1] = 16'h0BB;
    tick();
    skewed_valid_in = '0; skewed_data_in = '0;
  endtask

  initial begin
    rst = 1'b1;
    clear_in = 1'b0;
    skewed_data_in = '0;
    skewed_valid_in = '0;
    flat_ready_in = 1'b0;
    #12;
    chk("rst_valid", 64'(flat_valid_out), 64'd0);
    chk("rst_count", 64'(fifo_count), 64'd0);
    chk("rst_data", flat_data_out, 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_align_err", 64'(align_err), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single row {1,2,3,4}, ready high: visible exactly in cycle N.
    rows.delete();
    tmp_row[0] = 16'd1; tmp_row[1] = 16'd2; tmp_row[2] = 16'd3; tmp_row[3] = 16'd4;
    rows.push_back(tmp_row);
    stream(1, 0);
    chk("t1_row", flat_data_out, 64'h0004_0003_0002_0001);
    idle(3, 1'b1);

    // Signed extremes carried bit-exact.
    rows.delete();
    tmp_row[0] = 16'h8000; tmp_row[1] = 16'h7FFF; tmp_row[2] = 16'hFFFF; tmp_row[3] = 16'h0000;
    rows.push_back(tmp_row);
    stream(1, 0);
    chk("t6_row", flat_data_out, 64'h0000_FFFF_7FFF_8000);
    idle(2, 1'b1);

    // Six rows into a stalled FIFO: four kept, rows 5 and 6 dropped.
    make_rows(6, 16'h200);
    stream(6, 100);
    chk("t2_count_full", 64'(fifo_count), 64'd4);
    chk("t2_overflow", 64'(overflow), 64'd1);
    idle(6, 1'b1);

    clear_in = 1'b1;
    idle(1, 1'b0);
    clear_in = 1'b0;
    chk("clr_overflow", 64'(overflow), 64'd0);

    // Full FIFO popped in the same cycle a new row arrives.
    make_rows(5, 16'h300);
    stream(5, 7);
    chk("t3_overflow", 64'(overflow), 64'd0);
    idle(6, 1'b1);

    // Lane 2 one cycle late.
    flat_ready_in = 1'b0;
    skewed_valid_in = 4'b0001; skewed_data_in = '0; skewed_data_in[0] = 16'd5; tick();
    skewed_valid_in = 4'b0010; skewed_data_in = '0; skewed_data_in[1] = 16'd6; tick();
    skewed_valid_in = 4'b0000; skewed_data_in = '0; tick();
    skewed_valid_in = 4'b1100; skewed_data_in = '0;
    skewed_data_in[2] = 16'd7; skewed_data_in[3] = 16'd8;
`ifdef DESKEW_ALIGN_CHECK_EN
    ae_evt = 1;
`else
    row_evt = 1;
    exp_row[0] = 16'd5; exp_row[1] = 16'd6; exp_row[2] = 16'd0; exp_row[3] = 16'd8;
`endif
    tick();
    idle(2, 1'b0);
`ifdef DESKEW_ALIGN_CHECK_EN
    chk("t4_align_err", 64'(align_err), 64'd1);
    chk("t4_count", 64'(fifo_count), 64'd0);
`else
    chk("t4_align_err", 64'(align_err), 64'd0);
    chk("t4_count", 64'(fifo_count), 64'd1);
`endif
    idle(3, 1'b1);

    // Async reset with rows queued and one in flight.
    load_with_inflight();
    rst = 1'b1;
    #1;
    chk("t5r_valid", 64'(flat_valid_out), 64'd0);
    chk("t5r_count", 64'(fifo_count), 64'd0);
    chk("t5r_data", flat_data_out, 64'd0);
    chk("t5r_overflow", 64'(overflow), 64'd0);
    sb.delete(); exp_ovf = 1'b0; exp_ae = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    idle(4, 1'b0);
    make_rows(1, 16'h500);
    stream(1, 0);
    idle(2, 1'b1);

    // Synchronous clear with rows queued and one in flight.
    load_with_inflight();
    clear_in = 1'b1;
    idle(1, 1'b0);
    clear_in = 1'b0;
    chk("t5c_valid", 64'(flat_valid_out), 64'd0);
    chk("t5c_data", flat_data_out, 64'd0);
    idle(4, 1'b0);
    make_rows(1, 16'h600);
    stream(1, 0);
    idle(2, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
